// File: rtl/lcd_cmd_sched.sv
// -----------------------------------------------------------------------------
// lcd_cmd_sched
//
// Command scheduler in front of lcd_ctrl. After reset it sends BOOT_CMD once.
// After that it shares the single lcd_ctrl command port between N_REQ
// requesters using round-robin arbitration. Only one command is in flight at
// a time. A watchdog guards every command, and the completion status goes
// back to the requester that issued the command.
//
// Optional feature (compile-time macro LCD_SCHED_RETRY_EN):
//   If the macro is defined, a command that reports lcd_error when busy falls
//   on its first attempt is sent once more with the same code. done_err then
//   reflects the second attempt. Timeouts are never retried.
//   If the macro is not defined, each command gets a single attempt.
//
// Ports
//   clk, rstn     clock; asynchronous active-low reset
//   req_valid     per-requester request
//   req_cmd       slot i command at [3i+2:3i]
//   req_ready     one-hot, one-cycle accept pulse (Mealy, in IDLE)
//   done          one-cycle completion pulse to the owning requester
//   done_err      error status, qualified by done
//   init_done     high once BOOT_CMD has finished without error
//   sched_busy    high whenever the scheduler is not idle
//   timeout_err   sticky watchdog-expiry flag, cleared only by reset
//   lcd_command   command to lcd_ctrl, held from one ISSUE to the next
//   lcd_valid     one-cycle strobe to lcd_ctrl
//   lcd_busy      lcd_ctrl busy
//   lcd_error     lcd_ctrl error, sampled in the cycle busy falls
//   dbg_state     current FSM state (encoding of state_t)
//
// Request handshake: a requester raises req_valid[i] and holds req_cmd slot i
// stable. The request is accepted in the cycle req_ready[i] is high, which is
// also the cycle the command is latched. If req_valid drops before that cycle,
// the request is withdrawn and has no side effects.
// -----------------------------------------------------------------------------
module lcd_cmd_sched #(
  parameter int          N_REQ     = 2,
  parameter int          ACK_WAIT  = 16,
  parameter int          TIMEOUT_W = 22,
  parameter logic [2:0]  BOOT_CMD  = 3'd1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [3*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   done_err,
  output logic               init_done,
  output logic               sched_busy,
  output logic               timeout_err,
  output logic [2:0]         lcd_command,
  output logic               lcd_valid,
  input  logic               lcd_busy,
  input  logic               lcd_error,
  output logic [2:0]         dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_BOOT      = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic                   boot_q, boot_d;     // current command is the boot command
  logic [2:0]             cmd_q, cmd_d;
  logic                   err_q, err_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
  logic [2:0]             lcd_command_q;
  logic                   init_done_q, init_done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   busy_q;
`ifdef LCD_SCHED_RETRY_EN
  logic                   retry_q, retry_d;   // second attempt already used
`endif

  // Unpack the flat command bus into one entry per slot.
  logic [2:0] cmd_arr [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign cmd_arr[gi] = req_cmd[3*gi +: 3];
  end

  // Round-robin pick: the first valid slot at or after the pointer.
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   arb_sum;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(N_REQ)) arb_sum = arb_sum - (PW+1)'(N_REQ);
      if (!gnt_found && req_valid[arb_sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_sum[PW-1:0];
      end
    end
  end

  // The watchdog counts every cycle spent in WAIT_ACK and WAIT_DONE and stops
  // at all-ones.
  logic [TIMEOUT_W-1:0] wdog_inc;
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    boot_d        = boot_q;
    cmd_d         = cmd_q;
    err_d         = err_q;
    wdog_d        = wdog_q;
    init_done_d   = init_done_q;
    timeout_err_d = timeout_err_q;
`ifdef LCD_SCHED_RETRY_EN
    retry_d       = retry_q;
`endif
    req_ready     = '0;
    done          = '0;
    done_err      = '0;
    lcd_valid     = 1'b0;

    case (state_q)
      S_BOOT: begin
        cmd_d   = BOOT_CMD;
        boot_d  = 1'b1;
        owner_d = '0;
        err_d   = 1'b0;
`ifdef LCD_SCHED_RETRY_EN
        retry_d = 1'b0;
`endif
        state_d = S_ISSUE;
      end

      S_IDLE: begin
        if (gnt_found && init_done_q) begin
          req_ready[gnt_idx] = 1'b1;
          cmd_d   = cmd_arr[gnt_idx];
          owner_d = gnt_idx;
          boot_d  = 1'b0;
`ifdef LCD_SCHED_RETRY_EN
          retry_d = 1'b0;
`endif
          ptr_d   = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          // Command 0 is not a valid lcd_ctrl operation. It is rejected
          // without touching lcd_ctrl.
          if (cmd_arr[gnt_idx] == 3'd0) begin
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        lcd_valid = 1'b1;
        wdog_d    = '0;
        state_d   = S_WAIT_ACK;
      end

      // Busy is accepted on each of the ACK_WAIT cycles that follow the strobe.
      // After ACK_WAIT cycles in which busy stays low, the command times out.
      S_WAIT_ACK: begin
        wdog_d = wdog_inc;
        if (lcd_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wdog_q == TIMEOUT_W'(ACK_WAIT-1)) begin
          err_d         = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_REPORT;
        end
      end

      // lcd_error counts only in the cycle busy is seen low.
      S_WAIT_DONE: begin
        wdog_d = wdog_inc;
        if (!lcd_busy) begin
`ifdef LCD_SCHED_RETRY_EN
          if (lcd_error && !retry_q) begin
            retry_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            err_d   = lcd_error;
            state_d = S_REPORT;
          end
`else
          err_d   = lcd_error;
          state_d = S_REPORT;
`endif
        end else if (wdog_q == '1) begin
          err_d         = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_REPORT;
        end
      end

      S_REPORT: begin
        if (boot_q) begin
          // A failed init goes round again through BOOT.
          state_d = err_q ? S_BOOT : S_IDLE;
        end else begin
          done[owner_q]     = 1'b1;
          done_err[owner_q] = err_q;
          state_d           = S_IDLE;
        end
      end

      default: state_d = S_BOOT;
    endcase

    // init_done rises on entry to REPORT, so it is visible the cycle after
    // busy falls.
    if (boot_q && (state_d == S_REPORT) &&
        ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE)) && !err_d)
      init_done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_BOOT;
      ptr_q         <= '0;
      owner_q       <= '0;
      boot_q        <= 1'b1;
      cmd_q         <= '0;
      err_q         <= 1'b0;
      wdog_q        <= '0;
      lcd_command_q <= '0;
      init_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef LCD_SCHED_RETRY_EN
      retry_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      boot_q        <= boot_d;
      cmd_q         <= cmd_d;
      err_q         <= err_d;
      wdog_q        <= wdog_d;
      init_done_q   <= init_done_d;
      timeout_err_q <= timeout_err_d;
      if (state_d == S_ISSUE) lcd_command_q <= cmd_d;
      // sched_busy is registered from the next state so that it reads 0 while
      // in reset. After that it follows the state exactly.
      busy_q        <= (state_d != S_IDLE);
`ifdef LCD_SCHED_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign init_done   = init_done_q;
  assign timeout_err = timeout_err_q;
  assign sched_busy  = busy_q;
  assign lcd_command = lcd_command_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_lcd_cmd_sched
//
// Directed bench for lcd_cmd_sched. A behavioural lcd_ctrl model raises busy
// two cycles after each strobe. While busy is high it drives lcd_error high,
// so that only the value at the falling edge matters. The watchdog width is
// reduced to 8 so that the busy-stuck case stays short.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_sched;

  localparam int N_REQ     = 2;
  localparam int ACK_WAIT  = 16;
  localparam int TIMEOUT_W = 8;

  localparam logic [2:0] ST_BOOT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_REPORT    = 3'd5;

  logic               clk;
  logic               rstn;
  logic [N_REQ-1:0]   req_valid;
  logic [3*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   done_err;
  logic               init_done;
  logic               sched_busy;
  logic               timeout_err;
  logic [2:0]         lcd_command;
  logic               lcd_valid;
  logic               lcd_busy;
  logic               lcd_error;
  logic [2:0]         dbg_state;

  int n_err = 0;
  int n_chk = 0;

  lcd_cmd_sched #(
    .N_REQ(N_REQ), .ACK_WAIT(ACK_WAIT), .TIMEOUT_W(TIMEOUT_W), .BOOT_CMD(3'd1)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .done(done), .done_err(done_err),
    .init_done(init_done), .sched_busy(sched_busy), .timeout_err(timeout_err),
    .lcd_command(lcd_command), .lcd_valid(lcd_valid), .lcd_busy(lcd_busy),
    .lcd_error(lcd_error), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- lcd_ctrl model (updates on negedge) ----------------
  int         m_wait     = -1;
  int         m_left     = 0;
  int         m_busy_len = 100;
  int         m_ack_dly  = 2;
  int         m_err_cnt  = 0;   // number of upcoming busy falls that report error
  bit         m_no_ack   = 1'b0;
  bit         m_stuck    = 1'b0;
  int         n_valid    = 0;
  logic [2:0] last_cmd   = 3'd0;

  initial begin
    lcd_busy  = 1'b0;
    lcd_error = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        lcd_busy  = 1'b0;
        lcd_error = 1'b0;
        m_wait    = -1;
        m_left    = 0;
      end else begin
        if (m_wait == 0) begin
          lcd_busy  = 1'b1;
          lcd_error = 1'b1;
          m_left    = m_busy_len;
          m_wait    = -1;
        end else if (m_wait > 0) begin
          m_wait--;
        end else if (lcd_busy && !m_stuck) begin
          if (m_left > 1) m_left--;
          else begin
            lcd_busy  = 1'b0;
            lcd_error = (m_err_cnt > 0);
            if (m_err_cnt > 0) m_err_cnt--;
          end
        end
        if (lcd_valid) begin
          n_valid++;
          last_cmd = lcd_command;
          if (!m_no_ack) m_wait = m_ack_dly;
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  bit overlap_seen = 1'b0;
  bit multi_ready  = 1'b0;
  always @(negedge clk) begin
    if (rstn) begin
      if ((|done) && (|req_ready)) overlap_seen = 1'b1;
      if ((req_ready & (req_ready - 1'b1)) != '0) multi_ready = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, check the Mealy grant, then wait for done and check
  // the status. Returns the number of cycles from the first post-grant cycle
  // to the done pulse.
  task automatic do_req(input logic [1:0] vld, input logic [5:0] cmds,
                        input logic [1:0] exp_gnt, input logic [2:0] exp_cmd,
                        input logic exp_err, input int exp_nv, input int limit,
                        input string tag, output int lat);
    int nv0;
    nv0       = n_valid;
    req_valid = vld;
    req_cmd   = cmds;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_gnt));
    tick();
    req_valid = req_valid & ~exp_gnt;
    lat = 0;
    while (done == 2'b00 && lat < limit) begin
      tick();
      lat++;
    end
    chk({tag, ".done"}, 32'(done), 32'(exp_gnt));
    chk({tag, ".done_err"}, 32'(done_err), exp_err ? 32'(exp_gnt) : 32'd0);
    chk({tag, ".ready_at_done"}, 32'(req_ready), 32'd0);
    chk({tag, ".n_valid"}, 32'(n_valid - nv0), 32'(exp_nv));
    if (exp_nv > 0) chk({tag, ".cmd"}, 32'(last_cmd), 32'(exp_cmd));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  lat;
    int  k;
    bit  seen;
    bit  pre;
    bit  rdy_seen;
    int  nv0;

    rstn      = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    #2 rstn = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst.req_ready",   32'(req_ready),   32'd0);
    chk("rst.done",        32'(done),        32'd0);
    chk("rst.done_err",    32'(done_err),    32'd0);
    chk("rst.init_done",   32'(init_done),   32'd0);
    chk("rst.sched_busy",  32'(sched_busy),  32'd0);
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
    chk("rst.lcd_command", 32'(lcd_command), 32'd0);
    chk("rst.lcd_valid",   32'(lcd_valid),   32'd0);
    chk("rst.state",       32'(dbg_state),   32'(ST_BOOT));

    // 1: boot command
    rstn = 1'b1;
    tick();
    chk("boot.lcd_valid",   32'(lcd_valid),   32'd1);
    chk("boot.lcd_command", 32'(lcd_command), 32'd1);
    chk("boot.sched_busy",  32'(sched_busy),  32'd1);
    tick();
    chk("boot.valid_1cyc",  32'(lcd_valid),   32'd0);
    seen = 1'b0; pre = 1'b0; k = 0;
    while (!(seen && !lcd_busy) && k < 300) begin
      tick();
      k++;
      if (lcd_busy) begin
        seen = 1'b1;
        pre  = pre | init_done;
      end
    end
    chk("boot.init_while_busy", 32'(pre),       32'd0);
    chk("boot.init_done",       32'(init_done), 32'd1);
    chk("boot.state_report",    32'(dbg_state), 32'(ST_REPORT));
    chk("boot.no_done",         32'(done),      32'd0);
    tick();
    chk("boot.idle",       32'(dbg_state),  32'(ST_IDLE));
    chk("boot.idle_busy",  32'(sched_busy), 32'd0);
    chk("boot.one_valid",  32'(n_valid),    32'd1);
    chk("boot.cmd",        32'(last_cmd),   32'd1);

    m_busy_len = 5;

    // 2: round robin
    do_req(2'b11, {3'd5, 3'd2}, 2'b01, 3'd2, 1'b0, 1, 100, "rr_a0", lat);
    do_req(2'b10, {3'd5, 3'd2}, 2'b10, 3'd5, 1'b0, 1, 100, "rr_a1", lat);
    do_req(2'b11, {3'd3, 3'd4}, 2'b01, 3'd4, 1'b0, 1, 100, "rr_b",  lat);
    do_req(2'b11, {3'd3, 3'd6}, 2'b10, 3'd3, 1'b0, 1, 100, "rr_c",  lat);
    do_req(2'b01, {3'd3, 3'd6}, 2'b01, 3'd6, 1'b0, 1, 100, "rr_d",  lat);

    // 3: error reported when busy falls
    m_err_cnt = 1;
`ifdef LCD_SCHED_RETRY_EN
    do_req(2'b10, {3'd5, 3'd0}, 2'b10, 3'd5, 1'b0, 2, 100, "err", lat);
`else
    do_req(2'b10, {3'd5, 3'd0}, 2'b10, 3'd5, 1'b1, 1, 100, "err", lat);
`endif
    m_err_cnt = 0;

    // 5: command 0 is rejected without touching lcd_ctrl
    do_req(2'b01, {3'd0, 3'd0}, 2'b01, 3'd0, 1'b1, 0, 100, "cmd0", lat);
    chk("cmd0.latency", 32'(lat), 32'd0);

    // 4: busy never rises (16 cycles in WAIT_ACK, then REPORT)
    m_no_ack = 1'b1;
    do_req(2'b10, {3'd3, 3'd0}, 2'b10, 3'd3, 1'b1, 1, 100, "noack", lat);
    m_no_ack = 1'b0;
    chk("noack.latency",     32'(lat),         32'(ACK_WAIT + 1));
    chk("noack.timeout_err", 32'(timeout_err), 32'd1);
    do_req(2'b01, {3'd0, 3'd4}, 2'b01, 3'd4, 1'b0, 1, 100, "after_to", lat);
    chk("after_to.sticky",   32'(timeout_err), 32'd1);

    // Busy stuck high: watchdog expires at all-ones
    m_stuck = 1'b1;
    do_req(2'b10, {3'd6, 3'd0}, 2'b10, 3'd6, 1'b1, 1, 400, "stuck", lat);
    m_stuck = 1'b0;
    chk("stuck.latency", 32'(lat), 32'((1 << TIMEOUT_W) + 1));
    repeat (10) tick();

    // 6: reset during WAIT_DONE
    m_busy_len = 40;
    req_valid  = 2'b01;
    req_cmd    = {3'd0, 3'd7};
    #1;
    chk("mid.ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (10) tick();
    chk("mid.state", 32'(dbg_state), 32'(ST_WAIT_DONE));
    req_valid = 2'b10;
    req_cmd   = {3'd3, 3'd0};
    #2 rstn = 1'b0;
    #1;
    chk("mid.rst_busy",    32'(sched_busy),  32'd0);
    chk("mid.rst_timeout", 32'(timeout_err), 32'd0);
    chk("mid.rst_init",    32'(init_done),   32'd0);
    chk("mid.rst_cmd",     32'(lcd_command), 32'd0);
    chk("mid.rst_ready",   32'(req_ready),   32'd0);
    chk("mid.rst_state",   32'(dbg_state),   32'(ST_BOOT));
    tick();
    tick();
    rstn = 1'b1;
    nv0 = n_valid; rdy_seen = 1'b0; k = 0;
    while (!init_done && k < 300) begin
      tick();
      k++;
      rdy_seen = rdy_seen | (|req_ready);
    end
    chk("reinit.init_done",   32'(init_done),       32'd1);
    chk("reinit.no_grant",    32'(rdy_seen),        32'd0);
    chk("reinit.one_valid",   32'(n_valid - nv0),   32'd1);
    chk("reinit.cmd",         32'(last_cmd),        32'd1);
    m_busy_len = 5;
    tick();
    do_req(2'b10, {3'd3, 3'd0}, 2'b10, 3'd3, 1'b0, 1, 100, "pending", lat);

    chk("mon.done_ready_overlap", 32'(overlap_seen), 32'd0);
    chk("mon.ready_onehot",       32'(multi_ready),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
